// File: rtl/control_sequencer.sv
// Hardwired Moore control unit: fetch T0-T2, then a per-opcode execute sequence T3-T7.
// Optional macro CTRL_ILLEGAL_TRAP_EN: undefined opcodes latch Illegal and halt.
module control_sequencer #(
   parameter int unsigned OPW   = 5,
   parameter int unsigned STEPW = 3
) (
   input  logic        clock,
   input  logic        clear,
   input  logic [31:0] IR,
   input  logic        CON_FF,
   input  logic        stop,
   output logic        Gra, Grb, Grc,
   output logic        Rin, Rout, BAout, Cout,
   output logic        PCout, PCin, IncPC,
   output logic        MARin, MDRin, MDRout, Read, Write,
   output logic        IRin, RYin, RZin, RZHIout, RZLOout,
   output logic        HIin, HIout, LOin, LOout,
   output logic        PORTin, InPortout, CONin,
   output logic        Run,
   output logic        Illegal
);

   localparam logic [OPW-1:0] OP_LD   = OPW'(0);
   localparam logic [OPW-1:0] OP_LDI  = OPW'(1);
   localparam logic [OPW-1:0] OP_ST   = OPW'(2);
   localparam logic [OPW-1:0] OP_ADD  = OPW'(3);
   localparam logic [OPW-1:0] OP_ADDI = OPW'(12);
   localparam logic [OPW-1:0] OP_ORI  = OPW'(14);
   localparam logic [OPW-1:0] OP_DIV  = OPW'(15);
   localparam logic [OPW-1:0] OP_MUL  = OPW'(16);
   localparam logic [OPW-1:0] OP_NEG  = OPW'(17);
   localparam logic [OPW-1:0] OP_NOT  = OPW'(18);
   localparam logic [OPW-1:0] OP_BRX  = OPW'(19);
   localparam logic [OPW-1:0] OP_JR   = OPW'(20);
   localparam logic [OPW-1:0] OP_JAL  = OPW'(21);
   localparam logic [OPW-1:0] OP_IN   = OPW'(22);
   localparam logic [OPW-1:0] OP_OUT  = OPW'(23);
   localparam logic [OPW-1:0] OP_MFHI = OPW'(24);
   localparam logic [OPW-1:0] OP_MFLO = OPW'(25);
   localparam logic [OPW-1:0] OP_NOP  = OPW'(26);
   localparam logic [OPW-1:0] OP_HALT = OPW'(27);
   localparam logic [OPW-1:0] OP_UND  = OPW'(28);

   typedef enum logic [1:0] {EXEC, PAUSED, HALTED} mode_t;

   mode_t            mode;
   logic [STEPW-1:0] step;
   logic [STEPW-1:0] last;
   logic             primed;
   logic             active;
   logic             wrap;
   logic [OPW-1:0]   op;
   logic             is_nop, is_halt, is_undef, at_t2;
   logic             unused_ir;

   assign op        = IR[31 -: OPW];
   assign unused_ir = ^IR[31-OPW:0];
   assign is_nop    = (op == OP_NOP);
   assign is_halt   = (op == OP_HALT);
   assign is_undef  = (op >= OP_UND);
   assign at_t2     = primed && (step == STEPW'(2));
   assign active    = primed && (mode == EXEC);
   assign Run       = clear && (mode == EXEC);

   always_comb begin
      last = STEPW'(3);
      case (op) inside
         OP_LD:                                   last = STEPW'(7);
         OP_LDI, [OP_ADD:OP_ORI]:                 last = STEPW'(5);
         OP_ST, OP_DIV, OP_MUL, OP_BRX:           last = STEPW'(6);
         OP_NEG, OP_NOT, OP_JAL:                  last = STEPW'(4);
         default:                                 last = STEPW'(3);
      endcase
   end

   // primed=0 means no step is on the outputs yet; the next edge is an entry to T0
   assign wrap = !primed || (at_t2 && (is_nop || is_undef)) ||
                 ((step >= STEPW'(3)) && (step == last));

`ifdef CTRL_ILLEGAL_TRAP_EN
   logic illegal_q;
   assign Illegal = illegal_q;
`else
   assign Illegal = 1'b0;
`endif

   always_ff @(posedge clock or negedge clear) begin
      if (!clear) begin
         step   <= '0;
         mode   <= EXEC;
         primed <= 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
         illegal_q <= 1'b0;
`endif
      end else begin
         case (mode)
            EXEC: begin
               if (at_t2 && is_halt) begin
                  mode <= HALTED;
`ifdef CTRL_ILLEGAL_TRAP_EN
               end else if (at_t2 && is_undef) begin
                  mode      <= HALTED;
                  illegal_q <= 1'b1;
`endif
               end else if (wrap) begin
                  step <= '0;
                  if (stop) begin
                     mode   <= PAUSED;
                     primed <= 1'b0;
                  end else begin
                     primed <= 1'b1;
                  end
               end else begin
                  step <= step + STEPW'(1);
               end
            end
            PAUSED: begin
               if (!stop) begin
                  mode   <= EXEC;
                  step   <= '0;
                  primed <= 1'b1;
               end
            end
            default: mode <= HALTED;
         endcase
      end
   end

   always_comb begin
      {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC} = '0;
      {MARin, MDRin, MDRout, Read, Write, IRin, RYin, RZin, RZHIout, RZLOout} = '0;
      {HIin, HIout, LOin, LOout, PORTin, InPortout, CONin} = '0;
      if (active) begin
         case (step)
            STEPW'(0): begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; end
            STEPW'(1): begin Read = 1'b1; MDRin = 1'b1; end
            STEPW'(2): begin MDRout = 1'b1; IRin = 1'b1; end
            default: begin
               case (op) inside
                  [OP_ADD:OP_ORI]: case (step)
                     STEPW'(3): begin Grb = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                     STEPW'(4): begin
                        RZin = 1'b1;
                        if (op >= OP_ADDI) Cout = 1'b1;
                        else begin Grc = 1'b1; Rout = 1'b1; end
                     end
                     STEPW'(5): begin RZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
                  OP_DIV, OP_MUL: case (step)
                     STEPW'(3): begin Gra = 1'b1; Rout = 1'b1; RYin = 1'b1; end
                     STEPW'(4): begin Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; end
                     STEPW'(5): begin RZLOout = 1'b1; LOin = 1'b1; end
                     STEPW'(6): begin RZHIout = 1'b1; HIin = 1'b1; end
                     default: ;
                  endcase
                  OP_NEG, OP_NOT: case (step)
                     STEPW'(3): begin Grb = 1'b1; Rout = 1'b1; RZin = 1'b1; end
                     STEPW'(4): begin RZLOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
                  OP_LD, OP_LDI, OP_ST: case (step)
                     STEPW'(3): begin Grb = 1'b1; BAout = 1'b1; RYin = 1'b1; end
                     STEPW'(4): begin Cout = 1'b1; RZin = 1'b1; end
                     STEPW'(5): begin
                        RZLOout = 1'b1;
                        if (op == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                        else MARin = 1'b1;
                     end
                     STEPW'(6): begin
                        if (op == OP_ST) begin Gra = 1'b1; Rout = 1'b1; Write = 1'b1; end
                        else begin Read = 1'b1; MDRin = 1'b1; end
                     end
                     STEPW'(7): begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                     default: ;
                  endcase
                  OP_BRX: case (step)
                     STEPW'(3): begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                     STEPW'(4): begin PCout = 1'b1; RYin = 1'b1; end
                     STEPW'(5): begin Cout = 1'b1; RZin = 1'b1; end
                     STEPW'(6): begin RZLOout = 1'b1; PCin = CON_FF; end
                     default: ;
                  endcase
                  OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                  OP_JAL: case (step)
                     STEPW'(3): begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                     STEPW'(4): begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                     default: ;
                  endcase
                  OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; PORTin = 1'b1; end
                  OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                  default: ;
               endcase
            end
         endcase
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer; strobes are packed into one vector and
// compared with hand-built masks each negedge.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear, CON_FF, stop;
   logic [31:0] IR;
   logic Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC;
   logic MARin, MDRin, MDRout, Read, Write, IRin, RYin, RZin, RZHIout, RZLOout;
   logic HIin, HIout, LOin, LOout, PORTin, InPortout, CONin, Run, Illegal;
   logic [26:0] strobes;

   int n_pass  = 0;
   int n_total = 0;

   localparam logic [26:0] GRA = 27'h1 << 26, GRB = 27'h1 << 25, GRC = 27'h1 << 24;
   localparam logic [26:0] RIN = 27'h1 << 23, ROUT = 27'h1 << 22, BAOUT = 27'h1 << 21;
   localparam logic [26:0] COUT = 27'h1 << 20, PCOUT = 27'h1 << 19, PCIN = 27'h1 << 18;
   localparam logic [26:0] INCPC = 27'h1 << 17, MARIN = 27'h1 << 16, MDRIN = 27'h1 << 15;
   localparam logic [26:0] MDROUT = 27'h1 << 14, READ = 27'h1 << 13, WRITE = 27'h1 << 12;
   localparam logic [26:0] IRIN = 27'h1 << 11, RYIN = 27'h1 << 10, RZIN = 27'h1 << 9;
   localparam logic [26:0] RZHI = 27'h1 << 8, RZLO = 27'h1 << 7, HIIN = 27'h1 << 6;
   localparam logic [26:0] HIOUT = 27'h1 << 5, LOIN = 27'h1 << 4, LOOUT = 27'h1 << 3;
   localparam logic [26:0] PORTIN = 27'h1 << 2, INPORT = 27'h1 << 1, CONIN = 27'h1;

   control_sequencer #(.OPW(5), .STEPW(3)) dut (
      .clock(clock), .clear(clear), .IR(IR), .CON_FF(CON_FF), .stop(stop),
      .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout), .Cout(Cout),
      .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
      .MDRout(MDRout), .Read(Read), .Write(Write), .IRin(IRin), .RYin(RYin), .RZin(RZin),
      .RZHIout(RZHIout), .RZLOout(RZLOout), .HIin(HIin), .HIout(HIout), .LOin(LOin),
      .LOout(LOout), .PORTin(PORTin), .InPortout(InPortout), .CONin(CONin),
      .Run(Run), .Illegal(Illegal)
   );

   assign strobes = {Gra, Grb, Grc, Rin, Rout, BAout, Cout, PCout, PCin, IncPC, MARin, MDRin,
                     MDRout, Read, Write, IRin, RYin, RZin, RZHIout, RZLOout, HIin, HIout,
                     LOin, LOout, PORTin, InPortout, CONin};

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [26:0] exp_s, input logic exp_run);
      n_total += 2;
      assert (strobes === exp_s) n_pass++;
      else $error("FAIL %s strobes got %h want %h", tag, strobes, exp_s);
      assert (Run === exp_run) n_pass++;
      else $error("FAIL %s Run got %b want %b", tag, Run, exp_run);
   endtask

   task automatic chk_ill(input string tag, input logic exp_ill);
      n_total += 1;
      assert (Illegal === exp_ill) n_pass++;
      else $error("FAIL %s Illegal got %b want %b", tag, Illegal, exp_ill);
   endtask

   task automatic cyc(input string tag, input logic [26:0] exp_s, input logic exp_run);
      @(negedge clock);
      chk(tag, exp_s, exp_run);
   endtask

   // IR is updated once T0 is observed, well before the T2->T3 edge
   task automatic fetch(input string tag, input logic [31:0] ir);
      cyc({tag, "_T0"}, PCOUT | MARIN | INCPC, 1'b1);
      IR = ir;
      cyc({tag, "_T1"}, READ | MDRIN, 1'b1);
      cyc({tag, "_T2"}, MDROUT | IRIN, 1'b1);
   endtask

   initial begin
      clear = 1'b0; stop = 1'b0; CON_FF = 1'b0; IR = '0;
      #2;
      chk("reset", '0, 1'b0);
      chk_ill("reset_ill", 1'b0);
      @(negedge clock);
      clear = 1'b1;
      #1 chk("release", '0, 1'b1);

      fetch("add", 32'h19890000);
      cyc("add_T3", GRB | ROUT | RYIN, 1'b1);
      cyc("add_T4", GRC | ROUT | RZIN, 1'b1);
      cyc("add_T5", RZLO | GRA | RIN, 1'b1);

      fetch("ld", 32'h00800014);
      cyc("ld_T3", GRB | BAOUT | RYIN, 1'b1);
      cyc("ld_T4", COUT | RZIN, 1'b1);
      cyc("ld_T5", RZLO | MARIN, 1'b1);
      cyc("ld_T6", READ | MDRIN, 1'b1);
      cyc("ld_T7", MDROUT | GRA | RIN, 1'b1);

      CON_FF = 1'b0;
      fetch("brx0", 32'h98000000);
      cyc("brx0_T3", GRA | ROUT | CONIN, 1'b1);
      cyc("brx0_T4", PCOUT | RYIN, 1'b1);
      cyc("brx0_T5", COUT | RZIN, 1'b1);
      cyc("brx0_T6", RZLO, 1'b1);
      CON_FF = 1'b1;
      fetch("brx1", 32'h98000000);
      cyc("brx1_T3", GRA | ROUT | CONIN, 1'b1);
      cyc("brx1_T4", PCOUT | RYIN, 1'b1);
      cyc("brx1_T5", COUT | RZIN, 1'b1);
      cyc("brx1_T6", RZLO | PCIN, 1'b1);
      CON_FF = 1'b0;

      fetch("addi", 32'h60000000);
      cyc("addi_T3", GRB | ROUT | RYIN, 1'b1);
      cyc("addi_T4", COUT | RZIN, 1'b1);
      cyc("addi_T5", RZLO | GRA | RIN, 1'b1);

      fetch("jal", 32'hA8000000);
      cyc("jal_T3", PCOUT | GRB | RIN, 1'b1);
      cyc("jal_T4", GRA | ROUT | PCIN, 1'b1);

      fetch("nop", 32'hD0000000);

      fetch("st", 32'h10000000);
      cyc("st_T3", GRB | BAOUT | RYIN, 1'b1);
      cyc("st_T4", COUT | RZIN, 1'b1);
      cyc("st_T5", RZLO | MARIN, 1'b1);
      cyc("st_T6", GRA | ROUT | WRITE, 1'b1);

      fetch("ldstop", 32'h00800014);
      stop = 1'b1;
      cyc("ldstop_T3", GRB | BAOUT | RYIN, 1'b1);
      cyc("ldstop_T4", COUT | RZIN, 1'b1);
      cyc("ldstop_T5", RZLO | MARIN, 1'b1);
      cyc("ldstop_T6", READ | MDRIN, 1'b1);
      cyc("ldstop_T7", MDROUT | GRA | RIN, 1'b1);
      for (int i = 0; i < 5; i++) cyc("paused", '0, 1'b0);
      stop = 1'b0;

      fetch("halt", 32'hD8000000);
      for (int i = 0; i < 20; i++) cyc("halted", '0, 1'b0);
      clear = 1'b0;
      #1 chk("halt_rst", '0, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      #1 chk("halt_release", '0, 1'b1);

      fetch("mul", 32'h80000000);
      cyc("mul_T3", GRA | ROUT | RYIN, 1'b1);
      cyc("mul_T4", GRB | ROUT | RZIN, 1'b1);
      #1 clear = 1'b0;
      #1 chk("mul_rst", '0, 1'b0);
      @(negedge clock);
      clear = 1'b1;
      #1 chk("mul_release", '0, 1'b1);

      fetch("undef", 32'hF8000000);
`ifdef CTRL_ILLEGAL_TRAP_EN
      cyc("trap", '0, 1'b0);
      chk_ill("trap_ill", 1'b1);
      for (int i = 0; i < 3; i++) cyc("trap_hold", '0, 1'b0);
      chk_ill("trap_sticky", 1'b1);
`else
      chk_ill("undef_ill", 1'b0);
      fetch("mfhi", 32'hC0000000);
      chk_ill("undef_ill2", 1'b0);
      cyc("mfhi_T3", HIOUT | GRA | RIN, 1'b1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
